// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator (CPOL=0, CPHA=0), one full-duplex,
// MSB-first transfer of DATA_WIDTH bits per accepted request.
//
// Parameters
//   DATA_WIDTH  bits per transfer (2..32)
//   CLK_DIV     clk cycles per sck half-period; also the length of the CS
//               setup, CS hold and inter-transfer gap (>= 4)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   data_in         word to transmit, sampled in the accepting cycle
//   data_in_valid   start request, accepted only while busy = 0
//   data_out        last received word, held until the next completion
//   data_out_valid  one-cycle pulse when data_out updates
//   busy            transfer in progress; requests dropped while high
//   cs              chip select, active low
//   sck             serial clock, idle low
//   mosi            serial data out
//   miso            serial data in, asynchronous to clk
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  busy,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         half_cnt, half_cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] tx, tx_n;
    logic [DATA_WIDTH-1:0] rx, rx_n;
    logic [DATA_WIDTH-1:0] data_out_n;
    logic                  data_out_valid_n;
    logic                  busy_n, cs_n, sck_n, mosi_n;
    logic                  miso_s1, miso_s2;
    logic                  phase_done;

    assign phase_done = (half_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            half_cnt       <= '0;
            bit_cnt        <= '0;
            tx             <= '0;
            rx             <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            busy           <= 1'b0;
            cs             <= 1'b1;
            sck            <= 1'b0;
            mosi           <= 1'b0;
            miso_s1        <= 1'b0;
            miso_s2        <= 1'b0;
        end else begin
            state          <= state_n;
            half_cnt       <= half_cnt_n;
            bit_cnt        <= bit_cnt_n;
            tx             <= tx_n;
            rx             <= rx_n;
            data_out       <= data_out_n;
            data_out_valid <= data_out_valid_n;
            busy           <= busy_n;
            cs             <= cs_n;
            sck            <= sck_n;
            mosi           <= mosi_n;
            miso_s1        <= miso;
            miso_s2        <= miso_s1;
        end
    end

    always_comb begin
        state_n          = state;
        half_cnt_n       = '0;
        bit_cnt_n        = bit_cnt;
        tx_n             = tx;
        rx_n             = rx;
        data_out_n       = data_out;
        data_out_valid_n = 1'b0;
        busy_n           = busy;
        cs_n             = cs;
        sck_n            = sck;
        mosi_n           = mosi;

        // Half-period counter free-runs 0..CLK_DIV-1 in every active state.
        if (state != IDLE && !phase_done) begin
            half_cnt_n = half_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    state_n   = SETUP;
                    tx_n      = data_in;
                    rx_n      = '0;
                    bit_cnt_n = BW'(DATA_WIDTH - 1);
                    cs_n      = 1'b0;
                    busy_n    = 1'b1;
                    mosi_n    = data_in[DATA_WIDTH-1];
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_n = HIGH;
                    sck_n   = 1'b1;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    state_n = LOW;
                    sck_n   = 1'b0;
                    // miso_s2 here reflects the pin two cycles earlier.
                    rx_n    = {rx[DATA_WIDTH-2:0], miso_s2};
                    // Rotation keeps every tx bit live; only bit W-2 is
                    // ever presented after the first. Last bit: mosi holds.
                    if (bit_cnt != '0) begin
                        tx_n   = {tx[DATA_WIDTH-2:0], tx[DATA_WIDTH-1]};
                        mosi_n = tx[DATA_WIDTH-2];
                    end
                end
            end
            LOW: begin
                if (phase_done) begin
                    if (bit_cnt == '0) begin
                        state_n = HOLD;
                    end else begin
                        state_n   = HIGH;
                        bit_cnt_n = bit_cnt - 1'b1;
                        sck_n     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_n          = GAP;
                    cs_n             = 1'b1;
                    data_out_n       = rx;
                    data_out_valid_n = 1'b1;
                end
            end
            GAP: begin
                if (phase_done) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    mosi_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master (defaults
// DATA_WIDTH=8, CLK_DIV=4). Edge E is the rising edge just before the
// cycle in which data_in_valid is first presented; cs falls at E+1,
// sck rises at E+5+8k, cs rises / data_out_valid at E+73, busy falls
// at E+77. miso source is selected per step: loopback, constant 1,
// constant 0, or a small clk-synchronous mode-0 slave model.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       busy;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    logic [1:0]  mmode = 2'd0;
    logic [7:0]  slave_resp = 8'h00;
    logic [7:0]  s_tx = 8'h00;
    logic [7:0]  s_rx = 8'h00;
    logic        s_sck_d = 1'b0;

    int unsigned rises = 0;
    logic [31:0] mosi_bits = '0;
    int unsigned dv_count = 0;
    int unsigned sck_bad = 0;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .cs             (cs),
        .sck            (sck),
        .mosi           (mosi),
        .miso           (miso)
    );

    always #5 clk = ~clk;

    assign miso = (mmode == 2'd0) ? mosi :
                  (mmode == 2'd1) ? 1'b1 :
                  (mmode == 2'd2) ? 1'b0 : s_tx[7];

    // Bit recorder: mosi as seen at each sck rise.
    always @(posedge sck) begin
        rises     = rises + 1;
        mosi_bits = {mosi_bits[30:0], mosi};
    end

    always @(posedge clk) begin
        if (data_out_valid === 1'b1) dv_count = dv_count + 1;
        if (cs === 1'b1 && sck === 1'b1) sck_bad = sck_bad + 1;
    end

    // Mode-0 slave model: shifts out on sck fall, captures on sck rise.
    always @(posedge clk) begin
        if (cs !== 1'b0) begin
            s_tx    <= slave_resp;
            s_sck_d <= 1'b0;
        end else begin
            if (s_sck_d && !sck) s_tx <= {s_tx[6:0], 1'b0};
            if (!s_sck_d && sck) s_rx <= {s_rx[6:0], mosi};
            s_sck_d <= sck;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] din, input logic [7:0] exp_out,
                        input logic inject, input string tag);
        int unsigned r0;
        @(negedge clk);
        data_in       = din;
        data_in_valid = 1'b1;
        r0            = rises;
        @(negedge clk);                              // E+1
        data_in_valid = 1'b0;
        check({tag, "/cs_fall"}, 32'(cs), 32'd0);
        check({tag, "/busy_rise"}, 32'(busy), 32'd1);
        check({tag, "/mosi_msb"}, 32'(mosi), 32'(din[7]));
        step(3);                                     // E+4
        check({tag, "/sck_before_rise0"}, 32'(sck), 32'd0);
        step(1);                                     // E+5
        check({tag, "/sck_rise0"}, 32'(sck), 32'd1);
        step(5);                                     // E+10
        if (inject) begin
            data_in       = 8'h3C;
            data_in_valid = 1'b1;
        end
        step(1);                                     // E+11
        data_in_valid = 1'b0;
        step(61);                                    // E+72
        check({tag, "/dv_early"}, 32'(data_out_valid), 32'd0);
        check({tag, "/cs_held"}, 32'(cs), 32'd0);
        step(1);                                     // E+73
        check({tag, "/dv_pulse"}, 32'(data_out_valid), 32'd1);
        check({tag, "/cs_rise"}, 32'(cs), 32'd1);
        check({tag, "/data_out"}, 32'(data_out), 32'(exp_out));
        check({tag, "/sck_rises"}, rises - r0, 32'd8);
        check({tag, "/mosi_bits"}, 32'(mosi_bits[7:0]), 32'(din));
        step(1);                                     // E+74
        check({tag, "/dv_one_cycle"}, 32'(data_out_valid), 32'd0);
        step(2);                                     // E+76
        check({tag, "/busy_in_gap"}, 32'(busy), 32'd1);
        step(1);                                     // E+77
        check({tag, "/busy_fall"}, 32'(busy), 32'd0);
        check({tag, "/mosi_idle"}, 32'(mosi), 32'd0);
        check({tag, "/data_out_hold"}, 32'(data_out), 32'(exp_out));
    endtask

    initial begin
        int unsigned r0;
        int unsigned dv0;
        int unsigned hi;

        rst           = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        step(3);
        check("reset/cs", 32'(cs), 32'd1);
        check("reset/sck", 32'(sck), 32'd0);
        check("reset/mosi", 32'(mosi), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/dv", 32'(data_out_valid), 32'd0);
        check("reset/data_out", 32'(data_out), 32'd0);
        rst = 1'b1;
        step(2);

        // Loopback 0xA5.
        mmode = 2'd0;
        xfer(8'hA5, 8'hA5, 1'b0, "loop_a5");

        // Constant miso levels.
        mmode = 2'd1;
        xfer(8'h00, 8'hFF, 1'b0, "miso_one");
        mmode = 2'd2;
        xfer(8'h00, 8'h00, 1'b0, "miso_zero");

        // Request 0x3C at E+10 during a 0x55 transfer is dropped.
        mmode = 2'd0;
        dv0 = dv_count;
        xfer(8'h55, 8'h55, 1'b1, "ignore");
        step(20);
        check("ignore/no_second_xfer_cs", 32'(cs), 32'd1);
        check("ignore/no_second_xfer_dv", dv_count - dv0, 32'd1);

        // Back-to-back with data_in_valid held high.
        @(negedge clk);
        data_in       = 8'h12;
        data_in_valid = 1'b1;
        @(negedge clk);                              // E+1
        data_in = 8'h34;
        check("b2b/cs_fall1", 32'(cs), 32'd0);
        step(72);                                    // E+73
        check("b2b/dv1", 32'(data_out_valid), 32'd1);
        check("b2b/data_out1", 32'(data_out), 32'h12);
        // cs high spans the GAP phase plus the cycle in which the held
        // request is seen in IDLE: E+73 .. E+78.
        hi = 0;
        while (cs === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        check("b2b/cs_high_cycles", hi, 32'd5);
        data_in_valid = 1'b0;                        // E+78 = T2+1
        step(72);                                    // T2+73
        check("b2b/dv2", 32'(data_out_valid), 32'd1);
        check("b2b/data_out2", 32'(data_out), 32'h34);
        step(4);                                     // T2+77
        check("b2b/busy_fall2", 32'(busy), 32'd0);

        // Reset after three sck rises.
        @(negedge clk);
        data_in       = 8'h5A;
        data_in_valid = 1'b1;
        r0            = rises;
        @(negedge clk);                              // E+1
        data_in_valid = 1'b0;
        step(21);                                    // E+22
        check("abort/rises_before", rises - r0, 32'd3);
        dv0 = dv_count;
        rst = 1'b0;
        #1;
        check("abort/cs", 32'(cs), 32'd1);
        check("abort/sck", 32'(sck), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(80);
        check("abort/no_dv", dv_count - dv0, 32'd0);
        check("abort/data_out_cleared", 32'(data_out), 32'd0);
        xfer(8'hC3, 8'hC3, 1'b0, "after_abort");

        // Against the slave model returning 0x55.
        mmode      = 2'd3;
        slave_resp = 8'h55;
        xfer(8'h9A, 8'h55, 1'b0, "slave");
        check("slave/slave_rx", 32'(s_rx), 32'h9A);

        check("sck_only_with_cs", sck_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
